// File: rtl/mem_resp_rx.sv
// Remote-memory response receiver: matches MACK/MDATA packets against the spy's single
// outstanding request, returns load data, pulses unblock, and drains/counts bad packets.
module mem_resp_rx #(
  parameter int XY_SZ     = 3,
  parameter int OFFSET_SZ = 12,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_ctrl,
  input  logic                 clk_ctrl_rst_high,
  input  logic                 stream_in_TVALID,
  input  logic [31:0]          stream_in_TDATA,
  input  logic [3:0]           stream_in_TKEEP,
  input  logic                 stream_in_TLAST,
  output logic                 stream_in_TREADY,
  input  logic                 req_pending,
  input  logic                 req_is_load,
  input  logic [2*XY_SZ-1:0]   req_dest_id,
  output logic                 unblock,
  output logic [31:0]          mem_rdata_rv,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 rx_idle
);

  localparam int SRC_LO  = OFFSET_SZ + 2 * XY_SZ;
  localparam int SRC_HI  = OFFSET_SZ + 4 * XY_SZ - 1;
  localparam int CODE_LO = OFFSET_SZ + 4 * XY_SZ + 1;
  localparam logic [2:0] CODE_MACK  = 3'd1;
  localparam logic [2:0] CODE_MDATA = 3'd2;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W - 1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_TAIL  = 3'd2,
    S_DROP  = 3'd3,
    S_UNBLK = 3'd4
  } state_t;

  // Handshake: a beat moves on a rising clk_ctrl edge only when TVALID and TREADY are both 1;
  // TREADY depends on the state register alone, never on TVALID.
  state_t state_q, state_d;
  logic   is_mdata_q;
  logic   done_q;
  logic   beat;
  logic   hdr_match;
  logic   err_inc;
  logic   capture;
  logic [2*XY_SZ-1:0] hdr_src;
  logic [2:0]         hdr_code;
  logic               unused_keep;

  assign unused_keep      = ^stream_in_TKEEP;
  assign stream_in_TREADY = (state_q != S_UNBLK);
  assign rx_idle          = (state_q == S_HDR);
  assign beat             = stream_in_TVALID & stream_in_TREADY;
  assign hdr_src          = stream_in_TDATA[SRC_HI:SRC_LO];
  assign hdr_code         = stream_in_TDATA[CODE_LO+2:CODE_LO];

  // done_q blocks a second response to the same request from unblocking the spy again.
  assign hdr_match = req_pending && !done_q && (hdr_src == req_dest_id) &&
                     (((hdr_code == CODE_MDATA) && req_is_load) ||
                      ((hdr_code == CODE_MACK) && !req_is_load));

  always_comb begin
    state_d = state_q;
    err_inc = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_HDR: begin
        if (beat) begin
          if (stream_in_TLAST) begin
            err_inc = 1'b1;
          end else if (hdr_match) begin
            state_d = S_DATA;
          end else begin
            err_inc = 1'b1;
            state_d = S_DROP;
          end
        end
      end
      S_DATA: begin
        if (beat) begin
          capture = is_mdata_q;
          if (stream_in_TLAST) begin
            state_d = S_UNBLK;
          end else begin
            err_inc = 1'b1;
            state_d = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (beat && stream_in_TLAST) state_d = S_UNBLK;
      end
      S_DROP: begin
        if (beat && stream_in_TLAST) state_d = S_HDR;
      end
      S_UNBLK: state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst_high) begin
    if (clk_ctrl_rst_high) begin
      state_q      <= S_HDR;
      is_mdata_q   <= 1'b0;
      done_q       <= 1'b0;
      unblock      <= 1'b0;
      mem_rdata_rv <= '0;
      err_cnt      <= '0;
    end else begin
      state_q <= state_d;
      // Registered so the pulse coincides exactly with the S_UNBLK cycle.
      unblock <= (state_d == S_UNBLK);
      if (beat && (state_q == S_HDR)) is_mdata_q <= (hdr_code == CODE_MDATA);
      if (capture) mem_rdata_rv <= stream_in_TDATA;
      if (err_inc && (err_cnt != {ERR_CNT_W{1'b1}})) err_cnt <= err_cnt + ERR_ONE;
      if (state_q == S_UNBLK) begin
        done_q <= 1'b1;
      end else if (!req_pending) begin
        done_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_resp_rx.sv
// Bench for mem_resp_rx: packet-level reference model feeding an expected queue, a monitor
// checking each unblock pulse, and a second instance with a 2-bit error counter for saturation.
module tb_mem_resp_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tkeep = 4'hF;
  logic        tlast;
  logic        req_pending;
  logic        req_is_load;
  logic [5:0]  req_dest_id;

  logic        tready, unblock, idle;
  logic [31:0] rdata;
  logic [7:0]  err;
  logic        tready2, unblock2, idle2;
  logic [31:0] rdata2;
  logic [1:0]  err2;

  always #5 clk = ~clk;

  mem_resp_rx dut (
    .clk_ctrl(clk), .clk_ctrl_rst_high(rst),
    .stream_in_TVALID(tvalid), .stream_in_TDATA(tdata), .stream_in_TKEEP(tkeep),
    .stream_in_TLAST(tlast), .stream_in_TREADY(tready),
    .req_pending(req_pending), .req_is_load(req_is_load), .req_dest_id(req_dest_id),
    .unblock(unblock), .mem_rdata_rv(rdata), .err_cnt(err), .rx_idle(idle)
  );

  mem_resp_rx #(.ERR_CNT_W(2)) dut_sat (
    .clk_ctrl(clk), .clk_ctrl_rst_high(rst),
    .stream_in_TVALID(tvalid), .stream_in_TDATA(tdata), .stream_in_TKEEP(tkeep),
    .stream_in_TLAST(tlast), .stream_in_TREADY(tready2),
    .req_pending(req_pending), .req_is_load(req_is_load), .req_dest_id(req_dest_id),
    .unblock(unblock2), .mem_rdata_rv(rdata2), .err_cnt(err2), .rx_idle(idle2)
  );

  // Reference model state, at packet granularity.
  int          n_checks = 0;
  int          n_pass   = 0;
  int          err_m    = 0;
  logic        done_m   = 1'b0;
  logic [31:0] rdata_m  = 32'h0;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] err;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  function automatic logic [31:0] make_hdr(input logic [5:0] src, input logic [2:0] code);
    logic [31:0] h;
    h        = 32'h0;
    h[5:0]   = 6'($urandom_range(0, 63));
    h[17:6]  = 12'($urandom_range(0, 4095));
    h[23:18] = src;
    h[24]    = 1'($urandom_range(0, 1));
    h[27:25] = code;
    h[28]    = 1'($urandom_range(0, 1));
    return h;
  endfunction

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int gap;
    int w;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    w = 0;
    while (!tready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!tready) check("tready_timeout", 32'(tready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'($urandom_range(0, 1));
    tdata  = $urandom;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!idle && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!idle) check("idle_timeout", 32'(idle), 32'h1);
  endtask

  task automatic new_request();
    wait_idle();
    req_pending = 1'b0;
    @(negedge clk);
    done_m = 1'b0;
  endtask

  task automatic send_pkt(input logic pend, input logic load, input logic [5:0] dest,
                          input logic [5:0] src, input logic [2:0] code, input int nbeats,
                          input logic [31:0] pay1);
    logic        match;
    logic [31:0] d;
    wait_idle();
    req_pending = pend;
    req_is_load = load;
    req_dest_id = dest;
    if (!pend) done_m = 1'b0;
    match = pend && !done_m && (src == dest) &&
            ((code == 3'd2 && load) || (code == 3'd1 && !load));
    if (nbeats == 1) begin
      err_m++;
    end else if (match) begin
      if (nbeats > 2) err_m++;
      if (code == 3'd2) rdata_m = pay1;
      done_m = 1'b1;
      exp_q.push_back('{rdata: rdata_m, err: sat(err_m, 255)});
    end else begin
      err_m++;
    end
    send_beat(make_hdr(src, code), nbeats == 1);
    for (int i = 1; i < nbeats; i++) begin
      d = (i == 1) ? pay1 : $urandom;
      send_beat(d, i == nbeats - 1);
    end
    wait_idle();
    check("pkt_err_cnt", 32'(err), sat(err_m, 255));
    check("pkt_err_cnt_sat2", 32'(err2), sat(err_m, 3));
    check("pkt_rdata", rdata, rdata_m);
    check("pkt_rdata_sat2", rdata2, rdata_m);
    check("pkt_idle_sat2", 32'(idle2), 32'h1);
    check("pkt_unblock_seen", 32'(exp_q.size()), 32'h0);
  endtask

  // Monitor: every unblock pulse must correspond to an expected match.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && unblock) begin
      if (exp_q.size() == 0) begin
        check("spurious_unblock", 32'(unblock), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("unblock_rdata", rdata, e.rdata);
        check("unblock_err_cnt", 32'(err), e.err);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] dest, src;
    logic [2:0] code;
    int         nb;
    rst = 1'b1;
    tvalid = 1'b0; tdata = 32'h0; tlast = 1'b0;
    req_pending = 1'b0; req_is_load = 1'b0; req_dest_id = 6'h0;
    repeat (3) @(negedge clk);
    check("rst_tready", 32'(tready), 32'h1);
    check("rst_unblock", 32'(unblock), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err_cnt", 32'(err), 32'h0);
    check("rst_idle", 32'(idle), 32'h1);
    rst = 1'b0;
    @(negedge clk);

    new_request();
    send_pkt(1'b1, 1'b1, 6'h0A, 6'h0A, 3'd2, 2, 32'hDEADBEEF);
    new_request();
    send_pkt(1'b1, 1'b0, 6'h0A, 6'h0A, 3'd1, 2, 32'h12345678);
    new_request();
    send_pkt(1'b1, 1'b1, 6'h0A, 6'h03, 3'd2, 2, 32'h55AA55AA);
    send_pkt(1'b1, 1'b1, 6'h0A, 6'h0A, 3'd2, 2, 32'hC0FFEE01);
    send_pkt(1'b1, 1'b1, 6'h0A, 6'h0A, 3'd2, 1, 32'h0);
    new_request();
    send_pkt(1'b1, 1'b1, 6'h11, 6'h11, 3'd2, 3, 32'hA5A5F00D);
    new_request();
    send_pkt(1'b1, 1'b0, 6'h22, 6'h22, 3'd1, 2, 32'h0BADF00D);
    send_pkt(1'b1, 1'b0, 6'h22, 6'h22, 3'd1, 2, 32'h0BADF00D);
    for (int i = 0; i < 5; i++) send_pkt(1'b1, 1'b1, 6'h0A, 6'h0A, 3'd5, 2, $urandom);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) new_request();
      dest = ($urandom_range(0, 1) == 1) ? 6'h0A : 6'($urandom_range(0, 63));
      src  = ($urandom_range(0, 3) != 0) ? dest : 6'($urandom_range(0, 63));
      case ($urandom_range(0, 4))
        0, 1:    code = 3'd2;
        2, 3:    code = 3'd1;
        default: code = 3'($urandom_range(0, 7));
      endcase
      case ($urandom_range(0, 5))
        0:       nb = 1;
        1:       nb = 3;
        2:       nb = 4;
        default: nb = 2;
      endcase
      send_pkt($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), dest, src, code, nb,
               $urandom);
    end

    // Asynchronous reset while sitting in S_DATA with a payload beat offered.
    new_request();
    req_pending = 1'b1; req_is_load = 1'b1; req_dest_id = 6'h0A;
    tvalid = 1'b1; tdata = make_hdr(6'h0A, 3'd2); tlast = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_in_data", 32'(idle), 32'h0);
    tdata = 32'hFEEDFACE; tlast = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_tready", 32'(tready), 32'h1);
    check("arst_unblock", 32'(unblock), 32'h0);
    check("arst_rdata", rdata, 32'h0);
    check("arst_err_cnt", 32'(err), 32'h0);
    check("arst_idle", 32'(idle), 32'h1);
    check("arst_err_cnt_sat2", 32'(err2), 32'h0);
    check("arst_tready_sat2", 32'(tready2), 32'h1);
    check("arst_unblock_sat2", 32'(unblock2), 32'h0);
    err_m = 0; done_m = 1'b0; rdata_m = 32'h0;
    @(negedge clk);
    tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_pkt(1'b1, 1'b1, 6'h0A, 6'h0A, 3'd2, 2, 32'h13572468);

    repeat (5) @(negedge clk);
    check("final_exp_q_empty", 32'(exp_q.size()), 32'h0);
    check("final_err_cnt", 32'(err), sat(err_m, 255));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
